// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_pkg                                                         |
// | Purpose  : Shared types and constants for the PS/2 set-2 scan-code decoder:|
// |            decode FSM states, prefix and noise byte values, event-word     |
// |            bit positions and APB register offsets.                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } ps2_state_t;

   // Prefix bytes
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Keyboard status/response bytes that never form key events
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   // Bytes following E1 that belong to the Pause sequence
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Event word layout
   localparam int EVT_VALID_BIT = 31;
   localparam int EVT_PAUSE_BIT = 10;
   localparam int EVT_BRK_BIT   = 9;
   localparam int EVT_EXT_BIT   = 8;

   // Register offsets, decoded from paddr[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   // STATUS bit positions
   localparam int STAT_OVF_BIT   = 16;
   localparam int STAT_EMPTY_BIT = 17;

   function automatic logic is_noise(input logic [7:0] b);
      return (b == PS2_ERR0)   || (b == PS2_ERR1) || (b == PS2_BAT_OK) ||
             (b == PS2_ECHO)   || (b == PS2_ACK)  || (b == PS2_RESEND);
   endfunction

   function automatic logic [31:0] make_event(input logic       pause,
                                              input logic       brk,
                                              input logic       ext,
                                              input logic [7:0] code);
      logic [31:0] w_evt;
      w_evt                = '0;
      w_evt[EVT_VALID_BIT] = 1'b1;
      w_evt[EVT_PAUSE_BIT] = pause;
      w_evt[EVT_BRK_BIT]   = brk;
      w_evt[EVT_EXT_BIT]   = ext;
      w_evt[7:0]           = code;
      return w_evt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_evt_fifo                                                    |
// | Purpose  : Event FIFO with wrap-around pointers and occupancy counter.     |
// |            A push into a full FIFO is dropped (o_drop pulses) unless a pop |
// |            happens on the same edge; a pop of an empty FIFO is ignored.    |
// | Ports    : clock, reset         - clock, synchronous active-high reset     |
// |            i_push, i_push_data  - write request and data                   |
// |            i_pop                - consume head                             |
// |            o_head               - head entry (valid when !o_empty)         |
// |            o_count/o_full/o_empty - occupancy                              |
// |            o_drop               - push lost because FIFO was full          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_drop
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_pop_eff;
   logic w_push_eff;

   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // When full, a simultaneous pop frees the slot being written, so the push
   // lands in the entry that is leaving.
   assign w_pop_eff  = i_pop & ~o_empty;
   assign w_push_eff = i_push & (~o_full | w_pop_eff);
   assign o_drop     = i_push & ~w_push_eff;

   always_ff @(posedge clock) begin
      if (w_push_eff) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_eff) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_eff) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_eff, w_pop_eff})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_scancode_decoder                                            |
// | Purpose  : Folds PS/2 set-2 prefix sequences (E0, F0, E0 F0, E1 Pause)     |
// |            into single key events, buffers them and exposes them through  |
// |            a zero-wait APB slave (DATA / STATUS / CTRL).                   |
// | Ports    : clock, reset             - clock, synchronous active-high reset |
// |            in_data/in_valid/in_pop  - receiver FIFO head interface         |
// |            in_p*                    - APB slave                            |
// |            irq                      - level interrupt, events pending      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_pop,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   input  logic [2:0]  in_pprot,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic        irq
);

   ps2_state_t r_state;
   ps2_state_t w_next_state;
   logic [2:0] r_skip;
   logic [2:0] w_next_skip;
   logic       w_push;
   logic [31:0] w_push_data;

   logic       r_en;
   logic       r_irq_en;
   logic       r_ovf;
   logic       r_irq;

   logic [31:0]      w_head;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_drop;

   logic        w_access;
   logic        w_rd;
   logic        w_wr;
   logic [1:0]  w_reg;
   logic        w_pop;
   logic [31:0] w_status;

   logic w_unused_apb;

   // The upstream is never stalled; every presented byte is consumed.
   assign in_pop     = in_valid;
   assign in_pready  = 1'b1;
   assign in_pslverr = 1'b0;
   assign irq        = r_irq;

   assign w_unused_apb = ^{in_pstrb, in_pprot, in_paddr[31:4], in_paddr[1:0],
                           in_pwdata[31:17], in_pwdata[15:2], w_full};

   // ------------------------------------------------------------------ decode
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_skip  <= '0;
      end else begin
         r_state <= w_next_state;
         r_skip  <= w_next_skip;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_skip  = r_skip;
      w_push       = 1'b0;
      w_push_data  = '0;
      if (!r_en) begin
         // Disabled: bytes are still consumed but any partial prefix is lost.
         w_next_state = ST_IDLE;
         w_next_skip  = '0;
      end else if (in_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (in_data == PS2_EXT) begin
                  w_next_state = ST_EXT;
               end else if (in_data == PS2_BRK) begin
                  w_next_state = ST_BRK;
               end else if (in_data == PS2_PAUSE) begin
                  w_next_state = ST_PAUSE;
                  w_next_skip  = PAUSE_SKIP;
               end else if (!is_noise(in_data)) begin
                  w_push      = 1'b1;
                  w_push_data = make_event(1'b0, 1'b0, 1'b0, in_data);
               end
            end
            ST_EXT: begin
               if (in_data == PS2_BRK) begin
                  w_next_state = ST_EXT_BRK;
               end else begin
                  w_push       = 1'b1;
                  w_push_data  = make_event(1'b0, 1'b0, 1'b1, in_data);
                  w_next_state = ST_IDLE;
               end
            end
            ST_BRK: begin
               w_push       = 1'b1;
               w_push_data  = make_event(1'b0, 1'b1, 1'b0, in_data);
               w_next_state = ST_IDLE;
            end
            ST_EXT_BRK: begin
               w_push       = 1'b1;
               w_push_data  = make_event(1'b0, 1'b1, 1'b1, in_data);
               w_next_state = ST_IDLE;
            end
            ST_PAUSE: begin
               // Pause has no break code; the trailing bytes are only counted.
               if (r_skip == 3'd1) begin
                  w_push       = 1'b1;
                  w_push_data  = make_event(1'b1, 1'b0, 1'b0, PS2_PAUSE);
                  w_next_state = ST_IDLE;
                  w_next_skip  = '0;
               end else begin
                  w_next_skip = r_skip - 3'd1;
               end
            end
            default: begin
               w_next_state = ST_IDLE;
               w_next_skip  = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------ event FIFO
   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_drop      (w_drop)
   );

   // ------------------------------------------------------------------- APB
   assign w_access = in_psel & in_penable;
   assign w_rd     = w_access & ~in_pwrite;
   assign w_wr     = w_access &  in_pwrite;
   assign w_reg    = in_paddr[3:2];
   assign w_pop    = w_rd & (w_reg == REG_DATA) & ~w_empty;

   always_comb begin
      w_status                 = '0;
      w_status[CNT_W-1:0]      = w_count;
      w_status[STAT_OVF_BIT]   = r_ovf;
      w_status[STAT_EMPTY_BIT] = w_empty;
   end

   always_comb begin
      in_prdata = '0;
      if (w_rd) begin
         case (w_reg)
            REG_DATA:   in_prdata = w_empty ? 32'h0 : w_head;
            REG_STATUS: in_prdata = w_status;
            REG_CTRL:   in_prdata = {30'h0, r_irq_en, r_en};
            REG_RSVD:   in_prdata = '0;
            default:    in_prdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_en     <= 1'b1;
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && (w_reg == REG_CTRL)) begin
            r_en     <= in_pwdata[0];
            r_irq_en <= in_pwdata[1];
         end
         // A drop on the clearing edge wins so no overflow goes unreported.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_wr && (w_reg == REG_STATUS) && in_pwdata[STAT_OVF_BIT]) begin
            r_ovf <= 1'b0;
         end
         r_irq <= r_irq_en & (w_count != '0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ps2_scancode_decoder                                         |
// | Purpose  : Directed self-checking bench for ps2_scancode_decoder.          |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ps2_scancode_decoder;

   localparam logic [31:0] A_DATA   = 32'h0;
   localparam logic [31:0] A_STATUS = 32'h4;
   localparam logic [31:0] A_CTRL   = 32'h8;
   localparam logic [31:0] A_RSVD   = 32'hC;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_pop;
   logic [31:0] in_paddr = '0;
   logic        in_psel = 1'b0;
   logic        in_penable = 1'b0;
   logic        in_pwrite = 1'b0;
   logic [31:0] in_pwdata = '0;
   logic [3:0]  in_pstrb = 4'hF;
   logic [2:0]  in_pprot = '0;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   logic [31:0] rd;

   always #5 clock = ~clock;

   ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_pop     (in_pop),
      .in_paddr   (in_paddr),
      .in_psel    (in_psel),
      .in_penable (in_penable),
      .in_pwrite  (in_pwrite),
      .in_pwdata  (in_pwdata),
      .in_pstrb   (in_pstrb),
      .in_pprot   (in_pprot),
      .in_pready  (in_pready),
      .in_prdata  (in_prdata),
      .in_pslverr (in_pslverr),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      check("in_pop_hi", {31'h0, in_pop}, 32'h1);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      check("in_pop_lo", {31'h0, in_pop}, 32'h0);
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clock);
      in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0; in_paddr = addr;
      @(negedge clock);
      in_penable = 1'b1;
      #1;
      data = in_prdata;
      @(negedge clock);
      in_psel = 1'b0; in_penable = 1'b0;
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clock);
      in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b1; in_paddr = addr; in_pwdata = data;
      @(negedge clock);
      in_penable = 1'b1;
      @(negedge clock);
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
   endtask

   task automatic expect_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(addr, d);
      check(tag, d, exp);
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_pready", {31'h0, in_pready}, 32'h1);
      check("rst_pslverr", {31'h0, in_pslverr}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("idle_prdata", in_prdata, 32'h0);
      expect_read("rst_status", A_STATUS, 32'h0002_0000);
      expect_read("rst_ctrl", A_CTRL, 32'h0000_0001);

      // 1: make and break
      send(8'h1C); send(8'hF0); send(8'h1C);
      expect_read("t1_status", A_STATUS, 32'h0000_0002);
      expect_read("t1_make", A_DATA, 32'h8000_001C);
      expect_read("t1_break", A_DATA, 32'h8000_021C);
      expect_read("t1_empty", A_DATA, 32'h0000_0000);

      // 2: extended make and break
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      expect_read("t2_status_pre", A_STATUS, 32'h0000_0002);
      expect_read("t2_ext_make", A_DATA, 32'h8000_0175);
      expect_read("t2_ext_break", A_DATA, 32'h8000_0375);
      expect_read("t2_status_post", A_STATUS, 32'h0002_0000);

      // 3: Pause sequence then a normal key
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h1C);
      expect_read("t3_status", A_STATUS, 32'h0000_0002);
      expect_read("t3_pause", A_DATA, 32'h8000_04E1);
      expect_read("t3_make", A_DATA, 32'h8000_001C);
      expect_read("t3_empty", A_STATUS, 32'h0002_0000);

      // 4: noise dropped; disabled decoder discards bytes
      send(8'hAA); send(8'hFA); send(8'h00); send(8'hFF);
      expect_read("t4_noise", A_STATUS, 32'h0002_0000);
      apb_write(A_CTRL, 32'h0);
      expect_read("t4_ctrl_off", A_CTRL, 32'h0);
      send(8'h1C); send(8'hE0); send(8'h75);
      expect_read("t4_disabled", A_STATUS, 32'h0002_0000);
      apb_write(A_DATA, 32'h1234_5678);
      apb_write(A_RSVD, 32'hFFFF_FFFF);
      expect_read("t4_rsvd", A_RSVD, 32'h0);
      expect_read("t4_data_wr_ign", A_STATUS, 32'h0002_0000);

      // 5: irq lag, overflow, drain, ovf clear
      apb_write(A_CTRL, 32'h3);
      send(8'h01);
      check("t5_irq_lag", {31'h0, irq}, 32'h0);
      @(negedge clock);
      check("t5_irq_rise", {31'h0, irq}, 32'h1);
      for (int i = 2; i <= 9; i++) send(8'(i));
      expect_read("t5_full_ovf", A_STATUS, 32'h0001_0008);
      for (int i = 1; i <= 8; i++) expect_read("t5_drain", A_DATA, 32'h8000_0000 | 32'(i));
      expect_read("t5_ovf_kept", A_STATUS, 32'h0003_0000);
      @(negedge clock);
      check("t5_irq_fall", {31'h0, irq}, 32'h0);
      apb_write(A_STATUS, 32'h0001_0000);
      expect_read("t5_ovf_clr", A_STATUS, 32'h0002_0000);

      // 6: full FIFO, DATA read on the edge a new event completes
      for (int i = 8'h0A; i <= 8'h11; i++) send(8'(i));
      expect_read("t6_full", A_STATUS, 32'h0000_0008);
      @(negedge clock);
      in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0; in_paddr = A_DATA;
      @(negedge clock);
      in_penable = 1'b1; in_valid = 1'b1; in_data = 8'h12;
      #1;
      check("t6_head", in_prdata, 32'h8000_000A);
      @(negedge clock);
      in_psel = 1'b0; in_penable = 1'b0; in_valid = 1'b0;
      expect_read("t6_no_ovf", A_STATUS, 32'h0000_0008);
      for (int i = 8'h0B; i <= 8'h12; i++) expect_read("t6_drain", A_DATA, 32'h8000_0000 | 32'(i));
      expect_read("t6_empty", A_STATUS, 32'h0002_0000);

      // Reset mid-prefix discards the pending E0
      send(8'hE0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst2_irq", {31'h0, irq}, 32'h0);
      expect_read("rst2_ctrl", A_CTRL, 32'h0000_0001);
      send(8'h75);
      expect_read("rst2_make", A_DATA, 32'h8000_0075);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
